// File: rtl/pwm_cfg_scheduler_if.sv
// Decoder, register-file and update-request signals shared by the PWM config scheduler.
// The slave modport is the scheduler's view; master is the surrounding system's view.
interface pwm_cfg_scheduler_if;
   logic        host_read;
   logic        host_write;
   logic [5:0]  host_addr;
   logic [7:0]  host_wdata;
   logic [7:0]  host_rdata;
   logic        bus_read;
   logic        bus_write;
   logic [5:0]  bus_addr;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;
   logic        upd_valid;
   logic        upd_ready;
   logic [1:0]  upd_sel;
   logic [15:0] upd_data;
   logic        upd_sync;
   logic        upd_abort;
   logic [15:0] counter_val;
   logic        upd_done;
   logic        upd_err;

   modport slave (
      input  host_read, host_write, host_addr, host_wdata, bus_rdata,
      input  upd_valid, upd_sel, upd_data, upd_sync, upd_abort, counter_val,
      output host_rdata, bus_read, bus_write, bus_addr, bus_wdata,
      output upd_ready, upd_done, upd_err
   );

   modport master (
      output host_read, host_write, host_addr, host_wdata, bus_rdata,
      output upd_valid, upd_sel, upd_data, upd_sync, upd_abort, counter_val,
      input  host_rdata, bus_read, bus_write, bus_addr, bus_wdata,
      input  upd_ready, upd_done, upd_err
   );
endinterface

// File: rtl/pwm_cfg_scheduler.sv
// Splits 16-bit PWM register updates into two byte writes on a shared register-file bus,
// optionally deferred to counter zero, always yielding the bus to host decoder accesses.
module pwm_cfg_scheduler (
   input  logic               clk,
   input  logic               rst_n,
   pwm_cfg_scheduler_if.slave sif
);
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_SYNC = 3'd1,
      WR_LO     = 3'd2,
      WR_HI     = 3'd3,
      DONE      = 3'd4,
      ERR       = 3'd5
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [1:0]  sel_r;
   logic [15:0] data_r;
   logic        sync_r;

   logic        host_busy_s;
   logic        accept_s;
   logic        sched_wr_s;
   logic [5:0]  sched_addr_s;
   logic [7:0]  sched_wdata_s;

   function automatic logic [5:0] lo_addr(input logic [1:0] sel);
      case (sel)
         2'd0:    lo_addr = 6'h00;
         2'd1:    lo_addr = 6'h03;
         2'd2:    lo_addr = 6'h05;
         default: lo_addr = 6'h00;
      endcase
   endfunction

   function automatic logic [5:0] hi_addr(input logic [1:0] sel);
      case (sel)
         2'd0:    hi_addr = 6'h01;
         2'd1:    hi_addr = 6'h04;
         2'd2:    hi_addr = 6'h06;
         default: hi_addr = 6'h00;
      endcase
   endfunction

   assign host_busy_s = sif.host_read | sif.host_write;
   assign accept_s    = (state_r == IDLE) & sif.upd_valid;

   // State register and request capture; reset drops any pair in flight at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         sel_r   <= 2'd0;
         data_r  <= 16'h0000;
         sync_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            sel_r  <= sif.upd_sel;
            data_r <= sif.upd_data;
            sync_r <= sif.upd_sync;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (sif.upd_valid) begin
               if (sif.upd_sel == 2'd3) begin
                  state_nxt_s = ERR;
               end else if (sif.upd_sync) begin
                  state_nxt_s = WAIT_SYNC;
               end else begin
                  state_nxt_s = WR_LO;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT_SYNC: begin
            // Abort beats a coincident counter-zero.
            if (sif.upd_abort) begin
               state_nxt_s = ERR;
            end else if (!sync_r || (sif.counter_val == 16'h0000)) begin
               state_nxt_s = WR_LO;
            end else begin
               state_nxt_s = WAIT_SYNC;
            end
         end
         WR_LO: begin
            if (host_busy_s) begin
               state_nxt_s = WR_LO;
            end else begin
               state_nxt_s = WR_HI;
            end
         end
         WR_HI: begin
            if (host_busy_s) begin
               state_nxt_s = WR_HI;
            end else begin
               state_nxt_s = DONE;
            end
         end
         DONE:    state_nxt_s = IDLE;
         ERR:     state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Scheduler write decode; a host access in the same cycle stalls it.
   always_comb begin
      sched_wr_s    = 1'b0;
      sched_addr_s  = 6'h00;
      sched_wdata_s = 8'h00;
      if (!host_busy_s && (state_r == WR_LO)) begin
         sched_wr_s    = 1'b1;
         sched_addr_s  = lo_addr(sel_r);
         sched_wdata_s = data_r[7:0];
      end else if (!host_busy_s && (state_r == WR_HI)) begin
         sched_wr_s    = 1'b1;
         sched_addr_s  = hi_addr(sel_r);
         sched_wdata_s = data_r[15:8];
      end else begin
         sched_wr_s    = 1'b0;
         sched_addr_s  = 6'h00;
         sched_wdata_s = 8'h00;
      end
   end

   // Bus mux: host passthrough has absolute priority with no added latency.
   always_comb begin
      sif.bus_read  = sif.host_read;
      sif.bus_write = 1'b0;
      sif.bus_addr  = 6'h00;
      sif.bus_wdata = 8'h00;
      if (host_busy_s) begin
         sif.bus_write = sif.host_write;
         sif.bus_addr  = sif.host_addr;
         sif.bus_wdata = sif.host_wdata;
      end else begin
         sif.bus_write = sched_wr_s;
         sif.bus_addr  = sched_addr_s;
         sif.bus_wdata = sched_wdata_s;
      end
   end

   // Read return and status decode.
   always_comb begin
      sif.host_rdata = 8'h00;
      if (sif.host_read) begin
         sif.host_rdata = sif.bus_rdata;
      end else begin
         sif.host_rdata = 8'h00;
      end
   end

   assign sif.upd_ready = (state_r == IDLE);
   assign sif.upd_done  = (state_r == DONE);
   assign sif.upd_err   = (state_r == ERR);
endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Directed bench for pwm_cfg_scheduler: stimulus pushes time-stamped expected bus writes and
// done/err pulses into a queue; a negedge monitor pops and compares whatever the DUT presents.
module tb_pwm_cfg_scheduler;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   localparam int K_WR = 0;
   localparam int K_DONE = 1;
   localparam int K_ERR = 2;

   typedef struct {
      int         kind;
      logic [5:0] addr;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];

   pwm_cfg_scheduler_if ifc ();

   pwm_cfg_scheduler dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (ifc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int kind, input logic [5:0] addr, input logic [7:0] data, input int c);
      exp_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic mon_check(input int kind, input logic [5:0] addr, input logic [7:0] data);
      exp_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h at cycle %0d, expected nothing",
                  kind, addr, data, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.addr !== addr || e.data !== data || e.cyc != cyc) begin
            bad++;
            $display("FAIL event: got kind=%0d addr=%h data=%h cyc=%0d, expected kind=%0d addr=%h data=%h cyc=%0d",
                     kind, addr, data, cyc, e.kind, e.addr, e.data, e.cyc);
         end
      end
   endtask

   // Monitor: flags expected events that never appeared, then checks what the DUT shows.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         total++;
         bad++;
         $display("FAIL missing_event: got nothing, expected kind=%0d addr=%h data=%h cyc=%0d",
                  exp_q[0].kind, exp_q[0].addr, exp_q[0].data, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      if (ifc.bus_write) mon_check(K_WR, ifc.bus_addr, ifc.bus_wdata);
      if (ifc.upd_done)  mon_check(K_DONE, 6'h00, 8'h00);
      if (ifc.upd_err)   mon_check(K_ERR, 6'h00, 8'h00);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a request in the current cycle; returns the first cycle after acceptance.
   task automatic issue(input logic [1:0] sel, input logic [15:0] data, input logic sync, output int a);
      chk("ready_before_issue", {31'd0, ifc.upd_ready}, 32'd1);
      ifc.upd_valid = 1'b1;
      ifc.upd_sel   = sel;
      ifc.upd_data  = data;
      ifc.upd_sync  = sync;
      tick();
      ifc.upd_valid = 1'b0;
      ifc.upd_sel   = 2'd0;
      ifc.upd_data  = 16'h0000;
      ifc.upd_sync  = 1'b0;
      a = cyc;
   endtask

   initial begin
      int a;
      ifc.host_read   = 1'b0;
      ifc.host_write  = 1'b0;
      ifc.host_addr   = 6'h00;
      ifc.host_wdata  = 8'h00;
      ifc.bus_rdata   = 8'h00;
      ifc.upd_valid   = 1'b0;
      ifc.upd_sel     = 2'd0;
      ifc.upd_data    = 16'h0000;
      ifc.upd_sync    = 1'b0;
      ifc.upd_abort   = 1'b0;
      ifc.counter_val = 16'h0010;

      // Reset state
      #2;
      chk("rst_ready", {31'd0, ifc.upd_ready}, 32'd1);
      chk("rst_done", {31'd0, ifc.upd_done}, 32'd0);
      chk("rst_err", {31'd0, ifc.upd_err}, 32'd0);
      chk("rst_bus_write", {31'd0, ifc.bus_write}, 32'd0);
      chk("rst_bus_read", {31'd0, ifc.bus_read}, 32'd0);
      chk("rst_bus_addr", {26'd0, ifc.bus_addr}, 32'd0);
      chk("rst_bus_wdata", {24'd0, ifc.bus_wdata}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Immediate update
      issue(2'd1, 16'h1234, 1'b0, a);
      push(K_WR, 6'h03, 8'h34, a);
      push(K_WR, 6'h04, 8'h12, a + 1);
      push(K_DONE, 6'h00, 8'h00, a + 2);
      chk("imm_ready_busy", {31'd0, ifc.upd_ready}, 32'd0);
      repeat (3) tick();
      chk("imm_ready_after", {31'd0, ifc.upd_ready}, 32'd1);

      // Synced update, counter 5..0
      issue(2'd0, 16'h00FF, 1'b1, a);
      push(K_WR, 6'h00, 8'hFF, a + 6);
      push(K_WR, 6'h01, 8'h00, a + 7);
      push(K_DONE, 6'h00, 8'h00, a + 8);
      ifc.counter_val = 16'd5;
      for (int v = 4; v >= 0; v--) begin
         tick();
         ifc.counter_val = 16'(v);
      end
      tick();
      ifc.counter_val = 16'h0010;
      repeat (3) tick();
      chk("sync_ready_after", {31'd0, ifc.upd_ready}, 32'd1);

      // Host collision in WR_LO
      issue(2'd2, 16'hBEEF, 1'b0, a);
      ifc.host_write = 1'b1;
      ifc.host_addr  = 6'h0C;
      ifc.host_wdata = 8'h77;
      push(K_WR, 6'h0C, 8'h77, a);
      push(K_WR, 6'h0C, 8'h77, a + 1);
      push(K_WR, 6'h05, 8'hEF, a + 2);
      push(K_WR, 6'h06, 8'hBE, a + 3);
      push(K_DONE, 6'h00, 8'h00, a + 4);
      tick();
      tick();
      ifc.host_write = 1'b0;
      ifc.host_addr  = 6'h00;
      ifc.host_wdata = 8'h00;
      repeat (3) tick();
      chk("coll_ready_after", {31'd0, ifc.upd_ready}, 32'd1);

      // Invalid target
      issue(2'd3, 16'hFFFF, 1'b0, a);
      push(K_ERR, 6'h00, 8'h00, a);
      tick();
      chk("inv_ready_after", {31'd0, ifc.upd_ready}, 32'd1);

      // Abort while waiting, counter at 7
      issue(2'd2, 16'h1111, 1'b1, a);
      ifc.counter_val = 16'd7;
      push(K_ERR, 6'h00, 8'h00, a + 2);
      tick();
      ifc.upd_abort = 1'b1;
      tick();
      ifc.upd_abort = 1'b0;
      ifc.counter_val = 16'h0010;
      tick();
      chk("abort_ready_after", {31'd0, ifc.upd_ready}, 32'd1);

      // Reset while in WR_HI
      issue(2'd0, 16'hA55A, 1'b0, a);
      push(K_WR, 6'h00, 8'h5A, a);
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst_hi_bus_write", {31'd0, ifc.bus_write}, 32'd0);
      chk("rst_hi_ready", {31'd0, ifc.upd_ready}, 32'd1);
      chk("rst_hi_done", {31'd0, ifc.upd_done}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("rst_hi_ready_after", {31'd0, ifc.upd_ready}, 32'd1);

      // Host read passthrough
      ifc.host_read = 1'b1;
      ifc.host_addr = 6'h08;
      ifc.bus_rdata = 8'h5A;
      #1;
      chk("rd_rdata", {24'd0, ifc.host_rdata}, 32'h5A);
      chk("rd_bus_read", {31'd0, ifc.bus_read}, 32'd1);
      chk("rd_bus_addr", {26'd0, ifc.bus_addr}, 32'h08);
      chk("rd_bus_write", {31'd0, ifc.bus_write}, 32'd0);
      ifc.host_read = 1'b0;
      ifc.host_addr = 6'h00;
      #1;
      chk("rd_idle_rdata", {24'd0, ifc.host_rdata}, 32'h00);
      chk("rd_idle_bus_read", {31'd0, ifc.bus_read}, 32'd0);
      chk("rd_idle_bus_addr", {26'd0, ifc.bus_addr}, 32'h00);
      ifc.bus_rdata = 8'h00;

      repeat (4) tick();
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
